// File: rtl/iir_biquad_seq.sv
// Direct Form I biquad IIR with a single shared CW x DW multiplier stepped over
// five taps, plus rounding, saturation and valid/ready streaming on both sides.
module iir_biquad_seq #(
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int FRAC = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coef_we,
    input  logic [2:0]           coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 coef_busy,
    input  logic                 clr_state,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] y,
    output logic                 sat
);

    localparam int ACCW = DW + CW + 3;
    localparam int PW   = DW + CW;
    localparam logic signed [ACCW-1:0] HALF = ACCW'(2 ** (FRAC - 1));
    localparam logic signed [ACCW-1:0] YMAX = ACCW'(2 ** (DW - 1) - 1);
    localparam logic signed [ACCW-1:0] YMIN = ~YMAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT, HOLD} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             tap;
    logic signed [DW-1:0]   xs, x1, x2, y1, y2;
    logic signed [ACCW-1:0] acc;
    logic signed [CW-1:0]   coef [5];

    logic signed [CW-1:0]   mul_c;
    logic signed [DW-1:0]   mul_d;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext, rnd, r;
    logic signed [DW-1:0]   y_clamped;
    logic                   clamped;

    // Operand select for the shared multiplier
    always_comb begin
        mul_c = coef[0];
        mul_d = xs;
        case (tap)
            3'd1:    begin mul_c = coef[1]; mul_d = x1; end
            3'd2:    begin mul_c = coef[2]; mul_d = x2; end
            3'd3:    begin mul_c = coef[3]; mul_d = y1; end
            3'd4:    begin mul_c = coef[4]; mul_d = y2; end
            default: begin mul_c = coef[0]; mul_d = xs; end
        endcase
    end

    assign prod     = PW'(mul_c) * PW'(mul_d);
    assign prod_ext = {{(ACCW - PW){prod[PW-1]}}, prod};

    // Round half up, then clamp to the output range
    always_comb begin
        rnd       = acc + HALF;
        r         = rnd >>> FRAC;
        clamped   = 1'b0;
        y_clamped = r[DW-1:0];
        if (r > YMAX) begin
            y_clamped = YMAX[DW-1:0];
            clamped   = 1'b1;
        end else if (r < YMIN) begin
            y_clamped = YMIN[DW-1:0];
            clamped   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        coef_busy = (state != IDLE);
        case (state)
            IDLE:    if (in_valid)     state_nxt = MAC;
            MAC:     if (tap == 3'd4)  state_nxt = OUT;
            OUT:                       state_nxt = HOLD;
            HOLD:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
        if (clr_state) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap       <= '0;
            xs        <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            acc       <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            for (int i = 1; i < 5; i++) coef[i] <= '0;
            coef[0]   <= CW'(2 ** FRAC);
        end else if (clr_state) begin
            // coefficients and the last y survive a flush
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (coef_we) begin
                        case (coef_addr)
                            3'd0:    coef[0] <= coef_data;
                            3'd1:    coef[1] <= coef_data;
                            3'd2:    coef[2] <= coef_data;
                            3'd3:    coef[3] <= coef_data;
                            3'd4:    coef[4] <= coef_data;
                            default: ;
                        endcase
                    end
                    if (in_valid) begin
                        xs  <= x;
                        acc <= '0;
                        tap <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    tap <= tap + 3'd1;
                end
                OUT: begin
                    y         <= y_clamped;
                    out_valid <= 1'b1;
                    sat       <= sat | clamped;
                    x2        <= x1;
                    x1        <= xs;
                    y2        <= y1;
                    y1        <= y_clamped;
                end
                HOLD: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
